// File: rtl/ascon_arbiter.sv
// Two-requester, message-granular arbiter in front of a single ascon core.
// A requester owns the core from its first input block until the core returns
// its last output block, or until the drain timer expires. Ties in IDLE go to
// the round-robin pointer, which flips on every release.
module ascon_arbiter #(
  parameter int unsigned W       = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,

  // Requester 0
  input  logic         req0_mode,
  input  logic [W-1:0] req0_data,
  input  logic         req0_valid,
  input  logic         req0_last,
  output logic         req0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_valid,
  output logic         rsp0_last,

  // Requester 1
  input  logic         req1_mode,
  input  logic [W-1:0] req1_data,
  input  logic         req1_valid,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_valid,
  output logic         rsp1_last,

  // Core input side
  output logic         core_mode,
  output logic [W-1:0] core_block_in,
  output logic         core_in_valid,
  output logic         core_in_last,
  input  logic         core_in_ready,

  // Core output side
  input  logic [W-1:0] core_block_out,
  input  logic         core_out_valid,
  input  logic         core_out_last,

  // Status
  output logic         busy,
  output logic         owner,
  output logic         timeout_err
);

  // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain
  } state_e;

  state_e        state_q;
  logic          owner_q;
  logic          ptr_q;
  logic          mode_q;
  logic          terr_q;
  logic [TW-1:0] timer_q;

  logic         grant;
  logic         own_valid;
  logic         own_last;
  logic [W-1:0] own_data;
  logic         in_feed;
  logic         routing;
  logic         in_hs_last;
  logic         timer_expired;

  // Owner-side input mux and tie-break selection for a pending grant.
  always_comb begin
    grant     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    own_valid = owner_q ? req1_valid : req0_valid;
    own_last  = owner_q ? req1_last  : req0_last;
    own_data  = owner_q ? req1_data  : req0_data;
  end

  assign in_feed       = (state_q == StFeed);
  assign routing       = (state_q != StIdle);
  assign in_hs_last    = core_in_valid && core_in_ready && core_in_last;
  assign timer_expired = (timer_q >= TimerMax);

  // Core input follows the owner combinationally while feeding; zero otherwise.
  always_comb begin
    core_in_valid = in_feed && own_valid;
    core_in_last  = in_feed && own_valid && own_last;
    core_block_in = in_feed ? own_data : '0;
    req0_ready    = in_feed && !owner_q && core_in_ready;
    req1_ready    = in_feed &&  owner_q && core_in_ready;
  end

  // Core output is steered to the owner while a message is in flight.
  // Output beats arriving in IDLE are dropped.
  always_comb begin
    rsp0_valid = routing && !owner_q && core_out_valid;
    rsp0_last  = routing && !owner_q && core_out_valid && core_out_last;
    rsp0_data  = (routing && !owner_q) ? core_block_out : '0;
    rsp1_valid = routing &&  owner_q && core_out_valid;
    rsp1_last  = routing &&  owner_q && core_out_valid && core_out_last;
    rsp1_data  = (routing &&  owner_q) ? core_block_out : '0;
  end

  assign busy        = routing;
  assign owner       = owner_q;
  assign core_mode   = mode_q;
  assign timeout_err = terr_q;

  // Arbitration FSM with registered owner, mode, pointer, drain timer and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      mode_q  <= 1'b0;
      terr_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      terr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0_valid || req1_valid) begin
            owner_q <= grant;
            mode_q  <= grant ? req1_mode : req0_mode;
            state_q <= StFeed;
          end
        end
        StFeed: begin
          // A last output seen while still feeding is forwarded but does not release.
          if (in_hs_last) begin
            state_q <= StDrain;
            timer_q <= '0;
          end
        end
        StDrain: begin
          if (core_out_valid && core_out_last) begin
            state_q <= StIdle;
            ptr_q   <= ~ptr_q;
            timer_q <= '0;
          end else if (core_out_valid) begin
            timer_q <= '0;
          end else if (timer_expired) begin
            state_q <= StIdle;
            ptr_q   <= ~ptr_q;
            terr_q  <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_arbiter.sv
// Randomised bench for ascon_arbiter: a toy core model, a per-requester
// response scoreboard, and a message-level model of grant/release behaviour.
module tb_ascon_arbiter;

  localparam int W  = 64;
  localparam int TO = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } blk_t;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] data;
    logic         last;
  } cin_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         r_mode  [2];
  logic         r_valid [2];
  logic         r_last  [2];
  logic [W-1:0] r_data  [2];
  logic         msg_mode[2];

  logic         core_in_ready  = 1'b0;
  logic         core_out_valid = 1'b0;
  logic         core_out_last  = 1'b0;
  logic [W-1:0] core_block_out = '0;

  logic         req0_ready, req1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_valid, rsp1_valid, rsp0_last, rsp1_last;
  logic         core_mode, core_in_valid, core_in_last;
  logic [W-1:0] core_block_in;
  logic         busy, owner, timeout_err;

  int checks   = 0;
  int failures = 0;

  blk_t exp0_q[$];
  blk_t exp1_q[$];
  cin_t core_q[$];

  int  core_rdy_mode = 0;  // 0 random, 1 high, 2 low
  bit  mute          = 1'b0;
  bit  inject_idle   = 1'b0;
  int  idle_run      = 0;
  int  rsp_cnt[2];
  int  rdy0_cnt      = 0;
  int  terr_cnt      = 0;

  // Message-level model state.
  bit m_busy, m_drain, m_owner, m_ptr, m_mode, m_terr;
  int m_timer;

  always #5 clk = ~clk;

  ascon_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_mode      (r_mode[0]),
    .req0_data      (r_data[0]),
    .req0_valid     (r_valid[0]),
    .req0_last      (r_last[0]),
    .req0_ready     (req0_ready),
    .rsp0_data      (rsp0_data),
    .rsp0_valid     (rsp0_valid),
    .rsp0_last      (rsp0_last),
    .req1_mode      (r_mode[1]),
    .req1_data      (r_data[1]),
    .req1_valid     (r_valid[1]),
    .req1_last      (r_last[1]),
    .req1_ready     (req1_ready),
    .rsp1_data      (rsp1_data),
    .rsp1_valid     (rsp1_valid),
    .rsp1_last      (rsp1_last),
    .core_mode      (core_mode),
    .core_block_in  (core_block_in),
    .core_in_valid  (core_in_valid),
    .core_in_last   (core_in_last),
    .core_in_ready  (core_in_ready),
    .core_block_out (core_block_out),
    .core_out_valid (core_out_valid),
    .core_out_last  (core_out_last),
    .busy           (busy),
    .owner          (owner),
    .timeout_err    (timeout_err)
  );

  function automatic logic [W-1:0] xform(input logic m, input logic [W-1:0] d);
    return {d[W-9:0], d[W-1:W-8]} ^ (m ? 64'hA5A5_5A5A_0F0F_F0F0 : 64'h1234_5678_9ABC_DEF0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_core_mode"}, core_mode, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    check({tag, "_core_in"}, {core_in_valid, core_in_last}, 0);
    check({tag, "_rsp"}, {rsp0_valid, rsp0_last, rsp1_valid, rsp1_last}, 0);
  endtask

  // Toy core: queues accepted blocks, returns xform'd blocks a cycle or more later.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      core_in_ready  = 1'b0;
      core_out_valid = 1'b0;
      core_out_last  = 1'b0;
      idle_run       = 0;
    end else begin
      case (core_rdy_mode)
        1:       core_in_ready = 1'b1;
        2:       core_in_ready = 1'b0;
        default: core_in_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (inject_idle) begin
        core_out_valid = 1'b1;
        core_out_last  = 1'b1;
        core_block_out = 64'hDEAD_BEEF_0000_0001;
      end else if (!mute && core_q.size() > 0 &&
                   (idle_run >= 3 || $urandom_range(0, 2) != 0)) begin
        cin_t c;
        c = core_q.pop_front();
        core_out_valid = 1'b1;
        core_out_last  = c.last;
        core_block_out = xform(c.mode, c.data);
        idle_run       = 0;
      end else begin
        core_out_valid = 1'b0;
        core_out_last  = 1'b0;
        if (core_q.size() > 0) idle_run++;
      end
    end
  end

  // Monitor: compares DUT against model/scoreboard, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_drain = 0; m_owner = 0; m_ptr = 0; m_mode = 0; m_terr = 0; m_timer = 0;
      exp0_q.delete();
      exp1_q.delete();
      core_q.delete();
    end else begin
      bit nterr;
      bit g;
      blk_t e;
      check("busy", busy, m_busy);
      check("timeout_err", timeout_err, m_terr);
      if (m_busy) begin
        check("owner", owner, m_owner);
        check("core_mode", core_mode, m_mode);
      end
      check("req0_ready", req0_ready, m_busy && !m_drain && !m_owner && core_in_ready);
      check("req1_ready", req1_ready, m_busy && !m_drain &&  m_owner && core_in_ready);
      check("core_in_valid", core_in_valid, (m_busy && !m_drain) ? r_valid[m_owner] : 1'b0);
      if (m_busy && !m_drain && r_valid[m_owner]) begin
        check("core_block_in", core_block_in, r_data[m_owner]);
        check("core_in_last", core_in_last, r_last[m_owner]);
      end

      // Response scoreboard.
      if (exp0_q.size() == 0) check("rsp0_spurious", rsp0_valid, 0);
      else if (rsp0_valid) begin
        e = exp0_q.pop_front();
        check("rsp0_data", rsp0_data, e.data);
        check("rsp0_last", rsp0_last, e.last);
      end
      if (exp1_q.size() == 0) check("rsp1_spurious", rsp1_valid, 0);
      else if (rsp1_valid) begin
        e = exp1_q.pop_front();
        check("rsp1_data", rsp1_data, e.data);
        check("rsp1_last", rsp1_last, e.last);
      end
      if (rsp0_valid) rsp_cnt[0]++;
      if (rsp1_valid) rsp_cnt[1]++;
      if (req0_ready) rdy0_cnt++;
      if (timeout_err) terr_cnt++;

      // Record accepted blocks.
      if (core_in_valid && core_in_ready) begin
        cin_t c;
        c.mode = core_mode; c.data = core_block_in; c.last = core_in_last;
        core_q.push_back(c);
      end
      if (r_valid[0] && req0_ready) begin
        e.data = xform(msg_mode[0], r_data[0]); e.last = r_last[0];
        exp0_q.push_back(e);
      end
      if (r_valid[1] && req1_ready) begin
        e.data = xform(msg_mode[1], r_data[1]); e.last = r_last[1];
        exp1_q.push_back(e);
      end

      // Predict state after the coming edge.
      nterr = 0;
      if (!m_busy) begin
        if (r_valid[0] || r_valid[1]) begin
          g = (r_valid[0] && r_valid[1]) ? m_ptr : r_valid[1];
          m_busy = 1; m_drain = 0; m_owner = g; m_mode = r_mode[g];
        end
      end else if (!m_drain) begin
        if (r_valid[m_owner] && core_in_ready && r_last[m_owner]) begin
          m_drain = 1; m_timer = 0;
        end
      end else begin
        if (core_out_valid && core_out_last) begin
          m_busy = 0; m_drain = 0; m_ptr = ~m_ptr;
        end else if (core_out_valid) begin
          m_timer = 0;
        end else if (m_timer == TO - 1) begin
          m_busy = 0; m_drain = 0; m_ptr = ~m_ptr; nterr = 1;
        end else begin
          m_timer++;
        end
      end
      m_terr = nterr;
    end
  end

  task automatic send_msg(input int n, input int nb, input logic mode, input bit gaps,
                          input bit use_fd);
    int t;
    r_mode[n]   = mode;
    msg_mode[n] = mode;
    for (int b = 0; b < nb; b++) begin
      r_data[n]  = (use_fd && b == 1) ? 64'hD000000DC000000C : {$urandom, $urandom};
      r_last[n]  = (b == nb - 1);
      r_valid[n] = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if ((n == 0) ? req0_ready : req1_ready) break;
        if (++t > 400) begin
          bound_fail($sformatf("req%0d_accept_wait", n));
          break;
        end
      end
      @(posedge clk); #1;
      r_mode[n] = ~r_mode[n];  // must not disturb the latched core mode
      if (gaps && $urandom_range(0, 2) == 0) begin
        r_valid[n] = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    r_valid[n] = 1'b0;
    r_last[n]  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    forever begin
      @(negedge clk);
      if (!busy && exp0_q.size() == 0 && exp1_q.size() == 0 && core_q.size() == 0) break;
      if (++t > 2000) begin
        bound_fail(name);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_busy(input string name);
    int t = 0;
    forever begin
      @(negedge clk);
      if (busy) break;
      if (++t > 200) begin
        bound_fail(name);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      r_mode[i] = 0; r_valid[i] = 0; r_last[i] = 0; r_data[i] = '0; msg_mode[i] = 0;
      rsp_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("post_reset_idle");

    // Core output while IDLE must be dropped.
    @(negedge clk); inject_idle = 1'b1;
    @(negedge clk); inject_idle = 1'b0;
    @(posedge clk); #1;

    // Single three-block req0 message with an always-ready core.
    core_rdy_mode = 1;
    @(posedge clk); #1;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0; rdy0_cnt = 0;
    send_msg(0, 3, 1'b0, 1'b0, 1'b0);
    wait_idle("single_msg_drain");
    check("single_rsp0_blocks", rsp_cnt[0], 3);
    check("single_rsp1_blocks", rsp_cnt[1], 0);
    check("single_req0_ready_cycles", rdy0_cnt, 3);

    // Simultaneous requests from reset: req0, req1, then req0 again.
    do_reset();
    core_rdy_mode = 0;
    fork
      send_msg(0, 2, 1'b0, 1'b0, 1'b0);
      send_msg(1, 2, 1'b1, 1'b0, 1'b0);
    join
    wait_idle("rr_round1");
    fork
      send_msg(0, 1, 1'b1, 1'b0, 1'b0);
      send_msg(1, 1, 1'b0, 1'b0, 1'b0);
    join
    wait_idle("rr_round2");

    // Core stalls for four cycles in the middle of a message.
    core_rdy_mode = 1;
    fork
      send_msg(0, 5, 1'b0, 1'b0, 1'b1);
      begin
        wait_busy("stall_grant");
        core_rdy_mode = 2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        core_rdy_mode = 1;
      end
    join
    wait_idle("stall_drain");

    // Drain with a silent core must time out exactly once.
    terr_cnt = 0;
    mute = 1'b1;
    send_msg(0, 2, 1'b1, 1'b0, 1'b0);
    t = 0;
    forever begin
      @(negedge clk);
      if (timeout_err) break;
      if (++t > 50) begin
        bound_fail("timeout_wait");
        break;
      end
    end
    @(posedge clk); #1;
    exp0_q.delete();
    core_q.delete();
    mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("timeout_pulses", terr_cnt, 1);
    // Pointer has flipped on the timeout release; a tie now resolves by the model.
    fork
      send_msg(0, 1, 1'b0, 1'b0, 1'b0);
      send_msg(1, 1, 1'b1, 1'b0, 1'b0);
    join
    wait_idle("post_timeout_tie");

    // Reset in the middle of FEED, then req1 alone.
    core_rdy_mode = 2;
    r_mode[0] = 1'b1; r_data[0] = {$urandom, $urandom}; r_last[0] = 1'b0; r_valid[0] = 1'b1;
    wait_busy("abort_grant");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("abort_reset");
    @(posedge clk); #1;
    r_valid[0] = 1'b0;
    rst = 1'b0;
    core_rdy_mode = 0;
    send_msg(1, 4, 1'b1, 1'b1, 1'b0);
    wait_idle("after_abort");

    // Random traffic from both requesters.
    fork
      for (int i = 0; i < 25; i++) begin
        send_msg(0, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 25; i++) begin
        send_msg(1, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    join
    wait_idle("random_drain");
    check("end_exp0_empty", exp0_q.size(), 0);
    check("end_exp1_empty", exp1_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_arbiter.md
ASCON_ARBITER -- requirements
Module: ascon_arbiter

Interface
REQ-001 SHALL have parameter W, default 64: block width, matching the ascon core block ports.
REQ-002 SHALL have parameter TIMEOUT, default 1024: max DRAIN cycles without core output before forced release.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_mode, req1_mode  in  1  requester mode (MODE_ENC/MODE_DEC encoding of the core).
REQ-006 SHALL have ports req0_data, req1_data  in  W  requester input block.
REQ-007 SHALL have ports req0_valid, req1_valid / req0_last, req1_last  in  1  requester block valid / last block of message.
REQ-008 SHALL have ports req0_ready, req1_ready  out  1  requester block accepted when valid&ready.
REQ-009 SHALL have ports rsp0_data, rsp1_data  out  W  / rsp0_valid, rsp1_valid, rsp0_last, rsp1_last  out  1  per-requester result stream, no backpressure.
REQ-010 SHALL have ports core_mode out 1, core_block_in out W, core_in_valid out 1, core_in_last out 1, core_in_ready in 1: to ascon core input side.
REQ-011 SHALL have ports core_block_out in W, core_out_valid in 1, core_out_last in 1: from ascon core output side.
REQ-012 SHALL have ports busy out 1 (state != IDLE), owner out 1 (granted requester), timeout_err out 1 (one-cycle pulse).

Function
REQ-013 SHALL arbitrate at message granularity: grant held from first input block until core_out_last or timeout.
REQ-014 SHALL implement FSM IDLE -> FEED -> DRAIN -> IDLE.
REQ-015 IDLE: any reqN_valid high SHALL register grant; next cycle state FEED, owner=N, core_mode latched from reqN_mode.
REQ-016 Both valid in IDLE SHALL grant the requester not favoured by round-robin pointer's opposite, i.e. pointer names preferred requester; pointer toggles to the other requester on every release.
REQ-017 IDLE: all reqN_ready, core_in_valid, rspN_valid SHALL be 0; core_out_valid in IDLE SHALL be discarded.
REQ-018 FEED: core_block_in/core_in_valid/core_in_last SHALL combinationally mirror owner's data/valid/last; owner ready = core_in_ready; non-owner ready = 0.
REQ-019 FEED: handshake (core_in_valid & core_in_ready) with last=1 SHALL move to DRAIN next cycle; no further input accepted for that message.
REQ-020 FEED and DRAIN: core output SHALL combinationally route to owner's rsp (data/valid/last); non-owner rspN_valid = 0, rspN_last = 0.
REQ-021 core_out_last with core_out_valid in DRAIN SHALL return to IDLE next cycle; same event in FEED SHALL be forwarded and ignored for state.
REQ-022 core_mode SHALL remain stable from grant until release regardless of reqN_mode changes.
REQ-023 DRAIN timer SHALL reset to 0 on entry and on each core_out_valid, increment otherwise, saturating; reaching TIMEOUT-1 SHALL pulse timeout_err one cycle and return to IDLE, toggling pointer.
REQ-024 Grant latency SHALL be exactly one cycle: valid seen in IDLE at edge k, first possible handshake at edge k+1.
REQ-025 A new grant SHALL NOT be issued in the same cycle as release; IDLE lasts at least one cycle.
REQ-026 Owner dropping valid mid-message in FEED SHALL hold grant (no timeout in FEED).

Reset
REQ-027 rst high SHALL immediately force state IDLE, pointer=req0, owner=0, busy=0, core_mode=0, timeout_err=0, timer=0, all ready/valid/last outputs 0.
REQ-028 Reset mid-message SHALL abort the message; no partial state retained; first post-reset grant follows REQ-015.

Verification
REQ-029 Single req0 message, 3 blocks (last on 3rd), core_in_ready=1, core emits 3 blocks with last -> req0_ready high 3 cycles, rsp0 carries 3 blocks, rsp1_valid never 1, busy falls 1 cycle after core_out_last.
REQ-030 req0 and req1 valid same cycle after reset -> req0 granted first, req1_ready=0 throughout; after release req1 granted; third simultaneous request -> req0.
REQ-031 core_in_ready low 4 cycles mid-FEED -> owner ready low those cycles, no block lost or duplicated, data 64'hD000000DC000000C passed unchanged.
REQ-032 DRAIN with no core output, TIMEOUT=8 -> timeout_err pulses exactly once 8 cycles after DRAIN entry, state IDLE, pointer toggled.
REQ-033 Assert rst while in FEED -> all outputs 0 same cycle (before next edge); after deassert req1 alone granted with its latched mode.
REQ-034 req1 mode toggles during its message -> core_mode constant at grant value until release.
